// File: rtl/uart_rx_deserializer.sv
// ============================================================================
//  Module      : uart_rx_deserializer
//  Description : UART receive stage driven by a 16x baud tick; deserialises
//                7/8-bit frames with optional parity, flags framing/parity
//                errors and overflow. Optional macro RX_MAJORITY_VOTE_EN
//                enables 2-of-3 mid-bit voting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_deserializer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow,
    output logic       rx_busy
);

    localparam logic [3:0] c_mid_tick  = 4'd8;
    localparam logic [3:0] c_last_tick = 4'd15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0]             r_samp_cnt;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par_bad;
    logic                   r_cfg_bit8;
    logic                   r_cfg_par_en;
    logic                   r_cfg_odd;
    logic                   w_rx_sync;
    logic                   w_mid;
    logic                   w_last;
    logic                   w_sample;
    logic                   w_frame_done;
    logic                   w_load;
    logic [2:0]             w_bits_last;
    logic [7:0]             w_data_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= '1;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end

    assign w_rx_sync   = r_sync[SYNC_STAGES-1];
    assign w_mid       = baud_clock && (r_samp_cnt == c_mid_tick);
    assign w_last      = baud_clock && (r_samp_cnt == c_last_tick);
    assign w_bits_last = r_cfg_bit8 ? 3'd7 : 3'd6;
    // In 7-bit mode the bits sit in [7:1] after seven right shifts
    assign w_data_word = r_cfg_bit8 ? r_shift : {1'b0, r_shift[7:1]};

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] r_vote;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vote <= 2'b00;
        end else if (baud_clock) begin
            if (r_samp_cnt == 4'd6) r_vote[0] <= w_rx_sync;
            if (r_samp_cnt == 4'd7) r_vote[1] <= w_rx_sync;
        end
    end

    assign w_sample = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rx_sync) |
                      (r_vote[1] & w_rx_sync);
`else
    assign w_sample = w_rx_sync;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE:   if (baud_clock && !w_rx_sync) w_state_nxt = START;
            START: begin
                if (w_mid && w_sample) w_state_nxt = IDLE;
                else if (w_last)       w_state_nxt = DATA;
            end
            DATA: begin
                if (w_last && (r_bit_cnt == w_bits_last))
                    w_state_nxt = r_cfg_par_en ? PARITY : STOP;
            end
            PARITY: if (w_last) w_state_nxt = STOP;
            // Leave at mid-stop so a back-to-back start edge is not missed
            STOP: begin
                if (w_mid) begin
                    w_state_nxt  = IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_load = w_frame_done && (!rx_ready || read_rx_byte);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_samp_cnt   <= 4'd0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'd0;
            r_par_bad    <= 1'b0;
            r_cfg_bit8   <= 1'b0;
            r_cfg_par_en <= 1'b0;
            r_cfg_odd    <= 1'b0;
        end else if (baud_clock) begin
            if (r_state == IDLE && !w_rx_sync) begin
                r_samp_cnt   <= 4'd0;
                r_cfg_bit8   <= bit8;
                r_cfg_par_en <= parity_en;
                r_cfg_odd    <= odd_n_even;
            end else begin
                r_samp_cnt <= r_samp_cnt + 4'd1;
            end
            if (r_state == START && w_last)
                r_bit_cnt <= 3'd0;
            else if (r_state == DATA && w_last)
                r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_state == DATA && w_mid)
                r_shift <= {w_sample, r_shift[7:1]};
            if (r_state == PARITY && w_mid)
                r_par_bad <= w_sample ^ (^w_data_word) ^ r_cfg_odd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data     <= 8'd0;
            rx_ready    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
        end else if (w_load) begin
            rx_data     <= w_data_word;
            rx_ready    <= 1'b1;
            parity_err  <= r_par_bad & r_cfg_par_en;
            framing_err <= ~w_sample;
        end else if (w_frame_done) begin
            overflow    <= 1'b1;
        end else if (read_rx_byte && rx_ready) begin
            rx_ready    <= 1'b0;
            overflow    <= 1'b0;
        end
    end

    assign rx_busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: baud tick every 2 clk, 32 clk per bit.
`default_nettype none

module tb_uart_rx_deserializer;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_clock = 1'b0;
    logic       rx = 1'b1;
    logic       bit8 = 1'b1;
    logic       parity_en = 1'b0;
    logic       odd_n_even = 1'b0;
    logic       read_rx_byte = 1'b0;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;
    logic       rx_busy;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned g_start = 0;
    int unsigned done_cyc = 0;
    int unsigned offset = 0;
    exp_t        q[$];

    uart_rx_deserializer #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .read_rx_byte(read_rx_byte), .rx_data(rx_data), .rx_ready(rx_ready),
        .parity_err(parity_err), .framing_err(framing_err),
        .overflow(overflow), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // baud_clock mirrors cyc[0]: high for one clk out of every two
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        baud_clock = ~baud_clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation on every rising rx_ready, records busy falls
    initial begin
        logic prev_ready = 1'b0;
        logic prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_ready && !prev_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected: got data=%h with no frame pending", rx_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (rx_data !== e.d || parity_err !== e.pe ||
                        framing_err !== e.fe || overflow !== e.ov) begin
                        errors++;
                        $display("FAIL frame: got data=%h pe=%b fe=%b ov=%b expected data=%h pe=%b fe=%b ov=%b",
                                 rx_data, parity_err, framing_err, overflow, e.d, e.pe, e.fe, e.ov);
                    end
                end
            end
            if (prev_busy && !rx_busy) done_cyc = cyc;
            prev_ready = rx_ready;
            prev_busy  = rx_busy;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (32) step();
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe; e.ov = ov;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input int nbits, input logic has_par,
                        input logic par, input logic stop);
        while (cyc[0]) step();
        g_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par);
        drive_bit(stop);
        rx = 1'b1;
        repeat (40) step();
    endtask

    task automatic read_byte();
        read_rx_byte = 1'b1;
        step();
        read_rx_byte = 1'b0;
        step();
    endtask

    initial begin
        repeat (5) step();
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_ready", rx_ready, 1'b0);
        chk("reset_parity_err", parity_err, 1'b0);
        chk("reset_framing_err", framing_err, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        chk("reset_rx_busy", rx_busy, 1'b0);
        reset_n = 1'b1;
        repeat (10) step();

        // 8N1 0xA5
        push(8'hA5, 0, 0, 0);
        send(8'hA5, 8, 0, 0, 1);
        read_byte();
        chk("read_clears_ready", rx_ready, 1'b0);

        // 7-bit 0x3C with parity bit 1: even -> error, odd -> clean
        bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
        push(8'h3C, 1, 0, 0);
        send(8'h3C, 7, 1, 1, 1);
        read_byte();
        odd_n_even = 1'b1;
        push(8'h3C, 0, 0, 0);
        send(8'h3C, 7, 1, 1, 1);
        read_byte();

        // Bad stop bit, then a good frame clears framing_err
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        push(8'h55, 0, 1, 0);
        send(8'h55, 8, 0, 0, 0);
        read_byte();
        chk("framing_err_holds_after_read", framing_err, 1'b1);
        push(8'h12, 0, 0, 0);
        send(8'h12, 8, 0, 0, 1);
        read_byte();

        // False start: 4 ticks low
        while (cyc[0]) step();
        rx = 1'b0;
        repeat (8) step();
        rx = 1'b1;
        chk("false_start_busy", rx_busy, 1'b1);
        repeat (40) step();
        chk("false_start_idle", rx_busy, 1'b0);
        chk("false_start_no_ready", rx_ready, 1'b0);

`ifdef RX_MAJORITY_VOTE_EN
        // 0xFF with a glitch that only the samp_cnt==7 tick of data bit 0 sees
        push(8'hFF, 0, 0, 0);
        while (cyc[0]) step();
        drive_bit(1'b0);
        rx = 1'b1;
        repeat (15) step();
        rx = 1'b0;
        repeat (2) step();
        rx = 1'b1;
        repeat (15) step();
        for (int i = 1; i < 8; i++) drive_bit(1'b1);
        drive_bit(1'b1);
        repeat (40) step();
        read_byte();
`endif

        // Overflow: second frame is discarded
        push(8'h11, 0, 0, 0);
        send(8'h11, 8, 0, 0, 1);
        send(8'h22, 8, 0, 0, 1);
        chk("overflow_data_kept", rx_data, 8'h11);
        chk("overflow_set", overflow, 1'b1);
        chk("overflow_ready", rx_ready, 1'b1);
        read_byte();
        chk("read_clears_ready_ov", rx_ready, 1'b0);
        chk("read_clears_overflow", overflow, 1'b0);

        // Learn completion latency, then land a read on the load clock
        push(8'h33, 0, 0, 0);
        send(8'h33, 8, 0, 0, 1);
        offset = done_cyc - g_start;
        while (cyc[0]) step();
        fork
            send(8'h44, 8, 0, 0, 1);
            begin
                int unsigned target;
                target = cyc + offset - 1;
                while (cyc < target) step();
                read_rx_byte = 1'b1;
                step();
                read_rx_byte = 1'b0;
            end
        join
        chk("coincident_read_data", rx_data, 8'h44);
        chk("coincident_read_ready", rx_ready, 1'b1);
        chk("coincident_read_overflow", overflow, 1'b0);

        // Reset pulsed during data bit 3 of an all-ones frame
        while (cyc[0]) step();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        repeat (10) step();
        reset_n = 1'b0;
        repeat (2) step();
        chk("midframe_reset_data", rx_data, 8'h00);
        chk("midframe_reset_ready", rx_ready, 1'b0);
        chk("midframe_reset_overflow", overflow, 1'b0);
        chk("midframe_reset_busy", rx_busy, 1'b0);
        reset_n = 1'b1;
        repeat (200) step();
        chk("post_reset_no_frame", rx_ready, 1'b0);
        push(8'h0F, 0, 0, 0);
        send(8'h0F, 8, 0, 0, 1);
        read_byte();

        repeat (10) step();
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
